// File: rtl/demodulador_lockin_pkg.sv
// Shared definitions for the lock-in demodulator.
//   - Default widths for samples, references and accumulators.
//   - State encoding of the control FSM (exposed on the top's debug port).
//   - Helper that maps a requested cycle count of 0 onto 1.
package demodulador_lockin_pkg;

    localparam int DATA_W_DEF = 16;   // signed ADC sample width
    localparam int ACC_W_DEF  = 64;   // signed accumulator / result width
    localparam int REF_W      = 32;   // signed sine/cosine reference width
    localparam int CNT_W      = 32;   // width of M, N and their counters

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lockin_state_t;

    // A request of zero averaging cycles still has to produce results.
    function automatic logic [CNT_W-1:0] ciclos_efectivos(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

endpackage

// File: rtl/demodulador_lockin_mac.sv
// One multiply-accumulate channel of the lock-in demodulator.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   load            sample/reference pair is valid this cycle (stage 1 capture)
//   sample, ref_val signed sample and reference for the product
//   prod_valid      registered product is valid (stage 2 accumulate)
//   dump            the valid product closes the frame: publish acc+product, clear acc
//   result          last published frame sum, held between dumps
module mac_lockin
    import demodulador_lockin_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [REF_W-1:0]  ref_val,
    input  logic                     prod_valid,
    input  logic                     dump,
    output logic signed [ACC_W-1:0]  result
);

    localparam int PROD_W = DATA_W + REF_W;

    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;

    // Both operands widened first so the product keeps full precision.
    assign prod_d = PROD_W'(sample) * PROD_W'(ref_val);
    // Sign-extending size cast; the adder wraps on overflow by design.
    assign sum    = acc_q + ACC_W'(prod_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            acc_q  <= '0;
            result <= '0;
        end else begin
            if (load) begin
                prod_q <= prod_d;
            end
            if (prod_valid) begin
                if (dump) begin
                    result <= sum;
                    acc_q  <= '0;
                end else begin
                    acc_q  <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/demodulador_lockin.sv
// Lock-in demodulator: correlates ADC samples with sine/cosine references and
// publishes the in-phase (X) and quadrature (Y) sums once per frame of M*N samples.
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   enable                 processing enable; low freezes the accept path and counters
//   pts_x_ciclo            M, samples per reference cycle (latched per frame)
//   ciclos_promediar       N, reference cycles per result, 0 means 1 (latched per frame)
//   data_in, data_valid    signed sample and its strobe
//   ref_seno, ref_cos      references paired with the sample in the accept cycle
//   avanzar_en_tabla       pulse in every accept cycle, advances the reference table
//   data_out_x/y           frame sums, held between data_out_valid pulses
//   data_out_valid         one-cycle pulse, two cycles after the frame's last accept
//   state_dbg              current FSM state
//
// Handshake: there is no back-pressure. A sample is taken in any cycle where
// data_valid=1, enable=1 and the FSM is in RUN; data_valid in any other cycle is
// dropped and produces no avanzar_en_tabla pulse.
module demodulador_lockin
    import demodulador_lockin_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         pts_x_ciclo,
    input  logic [CNT_W-1:0]         ciclos_promediar,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    input  logic signed [REF_W-1:0]  ref_seno,
    input  logic signed [REF_W-1:0]  ref_cos,
    output logic                     avanzar_en_tabla,
    output logic signed [ACC_W-1:0]  data_out_x,
    output logic signed [ACC_W-1:0]  data_out_y,
    output logic                     data_out_valid,
    output lockin_state_t            state_dbg
);

    lockin_state_t    state_q, state_d;
    logic             accept;
    logic             entering_run;
    logic [CNT_W-1:0] m_lat, n_lat;
    logic [CNT_W-1:0] sample_cnt, cycle_cnt;
    logic             last_sample, last_cycle, last_of_frame;
    logic             v1_q, last1_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        entering_run     = 1'b0;
        avanzar_en_tabla = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = RUN;
                    entering_run = 1'b1;
                end
            end
            RUN: begin
                accept           = enable & data_valid;
                avanzar_en_tabla = enable & data_valid;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

    // ---------------- Frame counters ----------------
    assign last_sample   = (sample_cnt == m_lat - CNT_W'(1));
    assign last_cycle    = (cycle_cnt  == n_lat - CNT_W'(1));
    assign last_of_frame = accept & last_sample & last_cycle;

    // M and N are only sampled at frame starts, so a frame always uses one
    // consistent geometry even if the inputs change while it is running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_lat      <= CNT_W'(1);
            n_lat      <= CNT_W'(1);
            sample_cnt <= '0;
            cycle_cnt  <= '0;
        end else if (entering_run) begin
            m_lat      <= pts_x_ciclo;
            n_lat      <= ciclos_efectivos(ciclos_promediar);
            sample_cnt <= '0;
            cycle_cnt  <= '0;
        end else if (accept) begin
            if (last_sample) begin
                sample_cnt <= '0;
                if (last_cycle) begin
                    cycle_cnt <= '0;
                    m_lat     <= pts_x_ciclo;
                    n_lat     <= ciclos_efectivos(ciclos_promediar);
                end else begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
            end else begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- Pipeline control ----------------
    // Not gated by enable: products already in flight always complete.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q           <= 1'b0;
            last1_q        <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            v1_q           <= accept;
            last1_q        <= last_of_frame;
            data_out_valid <= v1_q & last1_q;
        end
    end

    mac_lockin #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_x (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .sample     (data_in),
        .ref_val    (ref_seno),
        .prod_valid (v1_q),
        .dump       (last1_q),
        .result     (data_out_x)
    );

    mac_lockin #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_y (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .sample     (data_in),
        .ref_val    (ref_cos),
        .prod_valid (v1_q),
        .dump       (last1_q),
        .result     (data_out_y)
    );

endmodule

// File: doc/demodulador_lockin.md
DEMODULADOR_LOCKIN -- requirements
Module: demodulador_lockin

Interface
REQ-001 Parameter DATA_W, default 16: width of signed input samples.
REQ-002 Parameter ACC_W, default 64: width of signed accumulators and result outputs.
REQ-003 clock  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  processing enable, shared with the reference generator; low pauses the block.
REQ-006 pts_x_ciclo  input  32  samples per reference cycle, M; legal range 2..2048, divisor of 2048.
REQ-007 ciclos_promediar  input  32  reference cycles per result, N; 0 is treated as 1.
REQ-008 data_in  input  DATA_W signed  ADC sample.
REQ-009 data_valid  input  1  data_in valid strobe, one sample per high cycle.
REQ-010 ref_seno  input  32 signed  current sine reference, zero-centred.
REQ-011 ref_cos  input  32 signed  current cosine reference, zero-centred.
REQ-012 avanzar_en_tabla  output  1  one-cycle pulse that advances the reference table index.
REQ-013 data_out_x  output  ACC_W signed  in-phase sum, sum of data_in*ref_seno.
REQ-014 data_out_y  output  ACC_W signed  quadrature sum, sum of data_in*ref_cos.
REQ-015 data_out_valid  output  1  one-cycle pulse when data_out_x/y update.

Function
REQ-016 A sample is accepted in a cycle where enable=1 and data_valid=1 and state is RUN; no other cycle accepts.
REQ-017 avanzar_en_tabla SHALL be high exactly in accepting cycles.
- Result: ref_seno/ref_cos presented in the accept cycle pair with that sample.
- The next reference value is ready one cycle later.
REQ-018 FSM states:
- IDLE: after reset; moves to RUN on the first cycle with enable=1.
- RUN: accepts samples.
- There is no exit from RUN except reset.
REQ-019 On entering RUN and at every frame boundary, M and N SHALL be latched; changes mid-frame take effect at the next frame.
REQ-020 Stage 1 SHALL register both products (DATA_W+32 bits, signed, full precision) in the cycle after accept.
REQ-021 Stage 2 SHALL add both products to ACC_W accumulators, sign-extended, with no saturation and wrap on overflow.
REQ-022 Sample counter runs 0..M-1 and wraps. Cycle counter increments on each sample-counter wrap and runs 0..N-1.
REQ-023 The frame's last sample is the one where sample=M-1 and cycle=N-1. When its product reaches stage 2:
- data_out_x/y <= acc + product.
- Accumulators <= 0.
- data_out_valid pulses.
- Latency: 2 cycles after the accept cycle.
REQ-024 Back-to-back frames SHALL lose no samples. A sample accepted the cycle after a frame's last sample belongs to the new frame.
REQ-025 enable=0 mid-frame SHALL freeze both counters and the accept path. Pipeline stages already loaded SHALL still complete. Results are identical to an unpaused run.
REQ-026 data_out_x/y SHALL hold their value between data_out_valid pulses.
REQ-027 data_valid while in IDLE or while enable=0 SHALL be ignored. No pulse on avanzar_en_tabla results.

Reset
REQ-028 reset_n low SHALL immediately force the following, at any time including mid-frame:
- state=IDLE
- counters=0
- accumulators=0
- pipeline valid flags=0
- avanzar_en_tabla=0
- data_out_x=0, data_out_y=0, data_out_valid=0
REQ-029 A partial frame interrupted by reset SHALL produce no data_out_valid.

Structure
REQ-030 The state encoding (IDLE, RUN) and default widths DATA_W=16, ACC_W=64 SHALL live in a shared lock-in package.
REQ-031 One sub-module, mac_lockin, SHALL implement one multiply-accumulate channel with a clear-on-dump input. It is instantiated twice, for X and Y.

Verification
REQ-032 M=4, N=1. Bench reference model reset to index 0 gives seno {0,32767,0,-32767} and cos {32767,0,-32767,0}. data_in {0,1000,0,-1000} -> X=65534000, Y=0, with data_out_valid 2 cycles after the 4th accept.
REQ-033 M=4, N=1, constant data_in=500 -> X=0, Y=0, valid once per 4 accepts, for 3 consecutive frames with no gap.
REQ-034 M=4, N=2, continuous valid, same stimulus as REQ-032 -> X=131068000 every 8 accepts. avanzar_en_tabla count equals the accept count.
REQ-035 Same stimulus as REQ-032 with enable low for 5 cycles after the 2nd sample -> identical X/Y. No avanzar_en_tabla pulses while enable is low.
REQ-036 reset_n asserted after 3 samples of a frame -> all outputs 0 immediately, no valid pulse. A following full frame gives X=65534000.
REQ-037 data_valid=1 with enable=0 for 10 cycles -> no avanzar_en_tabla, no accepts, outputs unchanged.
